// File: rtl/dev_uart_tx.sv
// dev_uart_tx: memory-mapped 8N1 UART transmitter with a byte FIFO and a drain interrupt.
// Define UART_TX_PARITY_EN to add an even-parity bit before the stop bit (11-bit frames).
module dev_uart_tx #(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [29:0] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ,
    output logic        txd
);
    localparam int            PW      = $clog2(FIFO_DEPTH);
    localparam int            CW      = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
    localparam logic PARITY_FLAG = 1'b1;
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    localparam logic PARITY_FLAG = 1'b0;
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    // ---------------- register decode ----------------
    logic [1:0] reg_sel;
    logic       wr_data;
    logic       wr_ctrl;
    logic       wr_status;

    assign reg_sel   = Addr[1:0];
    assign wr_data   = WE && (reg_sel == 2'd0);
    assign wr_ctrl   = WE && (reg_sel == 2'd1);
    assign wr_status = WE && (reg_sel == 2'd2);

    logic unused;
    assign unused = &{1'b0, Addr[29:2], Din[31:17], 1'b0};

    // ---------------- control / status registers ----------------
    logic [15:0] div_reg;
    logic        ie_reg;
    logic        ovf_reg;
    logic        irq_reg;
    logic [15:0] div_eff;

    assign div_eff = (div_reg == 16'd0) ? 16'd1 : div_reg;

    // ---------------- byte FIFO ----------------
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          fifo_empty;
    logic          fifo_full;
    logic          push;
    logic          pop;
    logic [7:0]    fifo_head;
    logic [4:0]    count5;

    assign fifo_empty = (count_reg == '0);
    assign fifo_full  = (count_reg == DEPTH_C);
    // Fullness is judged on the pre-edge count, so a pop in the same cycle cannot rescue a push.
    assign push       = wr_data && !fifo_full;
    assign fifo_head  = fifo_mem[rd_ptr_reg];
    assign count5     = 5'(count_reg);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= Din[7:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // ---------------- transmit FSM ----------------
    state_t      state_reg, state_next;
    logic [15:0] baud_cnt_reg, baud_cnt_next;
    logic [2:0]  bit_cnt_reg, bit_cnt_next;
    logic [7:0]  shift_reg, shift_next;
    logic        txd_reg, txd_next;
    logic        bit_end;
    logic        busy;

    assign bit_end = (baud_cnt_reg == 16'd1);
    assign busy    = (state_reg != S_IDLE);

`ifdef UART_TX_PARITY_EN
    logic parity_reg, parity_next;
`endif

    always_comb begin
        state_next    = state_reg;
        baud_cnt_next = baud_cnt_reg;
        bit_cnt_next  = bit_cnt_reg;
        shift_next    = shift_reg;
        pop           = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_next   = parity_reg;
`endif
        case (state_reg)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop           = 1'b1;
                    shift_next    = fifo_head;
                    bit_cnt_next  = 3'd0;
                    baud_cnt_next = div_eff;
                    state_next    = S_START;
`ifdef UART_TX_PARITY_EN
                    parity_next   = ^fifo_head;
`endif
                end
            end
            S_START: begin
                if (bit_end) begin
                    baud_cnt_next = div_eff;
                    state_next    = S_DATA;
                end else begin
                    baud_cnt_next = baud_cnt_reg - 16'd1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    baud_cnt_next = div_eff;
                    if (bit_cnt_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_next = S_PARITY;
`else
                        state_next = S_STOP;
`endif
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                        shift_next   = {1'b0, shift_reg[7:1]};
                    end
                end else begin
                    baud_cnt_next = baud_cnt_reg - 16'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    baud_cnt_next = div_eff;
                    state_next    = S_STOP;
                end else begin
                    baud_cnt_next = baud_cnt_reg - 16'd1;
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    // Chain straight into the next frame when data is waiting.
                    if (!fifo_empty) begin
                        pop           = 1'b1;
                        shift_next    = fifo_head;
                        bit_cnt_next  = 3'd0;
                        baud_cnt_next = div_eff;
                        state_next    = S_START;
`ifdef UART_TX_PARITY_EN
                        parity_next   = ^fifo_head;
`endif
                    end else begin
                        state_next = S_IDLE;
                    end
                end else begin
                    baud_cnt_next = baud_cnt_reg - 16'd1;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        txd_next = 1'b1;
        case (state_next)
            S_START:  txd_next = 1'b0;
            S_DATA:   txd_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: txd_next = parity_next;
`endif
            default:  txd_next = 1'b1;
        endcase
    end

    // Reset forces the line high immediately, abandoning any frame in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= S_IDLE;
            baud_cnt_reg <= 16'd1;
            bit_cnt_reg  <= 3'd0;
            shift_reg    <= 8'd0;
            txd_reg      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_reg   <= 1'b0;
`endif
        end else begin
            state_reg    <= state_next;
            baud_cnt_reg <= baud_cnt_next;
            bit_cnt_reg  <= bit_cnt_next;
            shift_reg    <= shift_next;
            txd_reg      <= txd_next;
`ifdef UART_TX_PARITY_EN
            parity_reg   <= parity_next;
`endif
        end
    end

    // ---------------- register updates and interrupt ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_reg <= DIV_RESET;
            ie_reg  <= 1'b0;
            ovf_reg <= 1'b0;
            irq_reg <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                div_reg <= Din[15:0];
                ie_reg  <= Din[16];
            end
            if (wr_data && fifo_full) begin
                ovf_reg <= 1'b1;
            end else if (wr_status && Din[3]) begin
                ovf_reg <= 1'b0;
            end
            irq_reg <= ie_reg && fifo_empty && !busy;
        end
    end

    always_comb begin
        Dout = 32'd0;
        case (reg_sel)
            2'd1:    Dout = {15'd0, ie_reg, div_reg};
            2'd2:    Dout = {19'd0, count5, 3'd0, PARITY_FLAG, ovf_reg, busy, fifo_full, fifo_empty};
            default: Dout = 32'd0;
        endcase
    end

    assign IRQ = irq_reg;
    assign txd = txd_reg;

endmodule

// File: tb/tb_dev_uart_tx.sv
// Scoreboard bench for dev_uart_tx: expected frames are queued at write time and a
// line monitor decodes txd cycle by cycle and compares against the queue.
module tb_dev_uart_tx;

`ifdef UART_TX_PARITY_EN
    localparam int          NB = 11;
    localparam logic [31:0] PF = 32'h0000_0010;
`else
    localparam int          NB = 10;
    localparam logic [31:0] PF = 32'h0000_0000;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [29:0] Addr = '0;
    logic        WE = 1'b0;
    logic [31:0] Din = '0;
    logic [31:0] Dout;
    logic        IRQ;
    logic        txd;

    dev_uart_tx #(.FIFO_DEPTH(8), .DIV_RESET(16'd16)) dut (
        .clk  (clk),
        .reset(reset),
        .Addr (Addr),
        .WE   (WE),
        .Din  (Din),
        .Dout (Dout),
        .IRQ  (IRQ),
        .txd  (txd)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        int         div;
    } frame_t;

    frame_t exp_q[$];
    int     start_q[$];
    int     total = 0;
    int     bad = 0;
    bit     mon_en = 1'b1;
    bit     mon_busy = 1'b0;

    // ---------------- line monitor ----------------
    frame_t     mf;
    logic [10:0] mbits;
    logic [7:0]  mgot;
    bit          merr;
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && reset && txd === 1'b0) begin
                mon_busy = 1'b1;
                start_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_frame: start bit at cycle %0d, required no frame", cyc);
                    repeat (NB * 16) @(negedge clk);
                end else begin
                    mf = exp_q.pop_front();
                    mbits = '1;
                    mbits[0] = 1'b0;
                    mbits[8:1] = mf.data;
`ifdef UART_TX_PARITY_EN
                    mbits[9] = ^mf.data;
`endif
                    merr = 1'b0;
                    mgot = '0;
                    for (int b = 0; b < NB; b++) begin
                        for (int c = 0; c < mf.div; c++) begin
                            if (b != 0 || c != 0) @(negedge clk);
                            if (txd !== mbits[b]) merr = 1'b1;
                            if (b >= 1 && b <= 8 && c == mf.div / 2) mgot[b-1] = txd;
                        end
                    end
                    total++;
                    if (merr) begin
                        bad++;
                        $display("FAIL frame: got=%02h required=%02h div=%0d (line shape wrong)", mgot, mf.data, mf.div);
                    end else begin
                        $display("frame ok: data=%02h div=%0d", mgot, mf.div);
                    end
                end
                mon_busy = 1'b0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        Addr = {28'd0, a};
        Din  = d;
        WE   = 1'b1;
        @(posedge clk);
        #1;
        WE = 1'b0;
        $display("write addr=%0d data=%08h", a, d);
    endtask

    task automatic send(input logic [7:0] b, input int div, input bit accepted);
        frame_t f;
        f.data = b;
        f.div  = div;
        if (accepted) exp_q.push_back(f);
        wr(2'd0, {24'd0, b});
    endtask

    task automatic chk_reg(input logic [1:0] a, input logic [31:0] expv, input string nm);
        Addr = {28'd0, a};
        WE   = 1'b0;
        #1;
        total++;
        if (Dout !== expv) begin
            bad++;
            $display("FAIL %s: Dout=%08h required=%08h", nm, Dout, expv);
        end else begin
            $display("read %s: Dout=%08h", nm, Dout);
        end
    endtask

    task automatic chk_bit(input logic act, input logic expv, input string nm);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got=%b required=%b", nm, act, expv);
        end else begin
            $display("check %s: %b", nm, act);
        end
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || mon_busy) && n < limit) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (exp_q.size() != 0 || mon_busy) begin
            bad++;
            $display("FAIL drain_timeout: pending=%0d required=0", exp_q.size());
        end
        repeat (4) @(negedge clk);
    endtask

    // ---------------- directed tests ----------------
    int t0;
    int target;
    initial begin
        repeat (3) @(negedge clk);
        chk_bit(txd, 1'b1, "txd_in_reset");
        reset = 1'b1;
        @(negedge clk);
        chk_bit(txd, 1'b1, "txd_after_reset");
        chk_bit(IRQ, 1'b0, "irq_after_reset");
        chk_reg(2'd2, 32'h1 | PF, "status_reset");
        chk_reg(2'd1, 32'h0000_0010, "ctrl_reset");
        chk_reg(2'd0, 32'h0, "data_reads_zero");
        chk_reg(2'd3, 32'h0, "reg3_reads_zero");

        // Frame shape and push latency, DIV=4
        wr(2'd1, 32'h0000_0004);
        send(8'hA5, 4, 1'b1);
        @(negedge clk);
        chk_bit(txd, 1'b1, "txd_high_write_cycle");
        @(negedge clk);
        chk_bit(txd, 1'b0, "txd_falls_n_plus_1");
        repeat (NB * 4 - 1) @(negedge clk);
        chk_reg(2'd2, 32'h5 | PF, "busy_last_cycle");
        @(negedge clk);
        chk_reg(2'd2, 32'h1 | PF, "idle_after_frame");
        drain(200);

        // DIV=0 behaves as DIV=1
        wr(2'd1, 32'h0000_0000);
        @(negedge clk);
        chk_reg(2'd1, 32'h0, "ctrl_div0_readback");
        send(8'h81, 1, 1'b1);
        drain(100);

        // Back-to-back frames at DIV=1
        wr(2'd1, 32'h0000_0001);
        start_q.delete();
        send(8'h01, 1, 1'b1);
        send(8'h02, 1, 1'b1);
        send(8'h03, 1, 1'b1);
        @(negedge clk);
        chk_reg(2'd2, 32'h204 | PF, "count_2");
        repeat (NB - 1) @(negedge clk);
        chk_reg(2'd2, 32'h104 | PF, "count_1");
        repeat (NB) @(negedge clk);
        chk_reg(2'd2, 32'h005 | PF, "count_0");
        repeat (NB) @(negedge clk);
        chk_reg(2'd2, 32'h001 | PF, "idle_after_burst");
        drain(100);
        total++;
        if (start_q.size() != 3) begin
            bad++;
            $display("FAIL burst_frames: got=%0d frames required=3", start_q.size());
        end else begin
            $display("burst starts: %0d %0d %0d", start_q[0], start_q[1], start_q[2]);
            total++;
            if (start_q[1] - start_q[0] != NB || start_q[2] - start_q[1] != NB) begin
                bad++;
                $display("FAIL burst_gap: got=%0d,%0d cycles required=%0d", start_q[1] - start_q[0], start_q[2] - start_q[1], NB);
            end
        end

        // Overflow at DIV=100, then push while full in the pop cycle
        wr(2'd1, 32'd100);
        send(8'h10, 100, 1'b1);
        t0 = cyc;
        for (int i = 1; i < 10; i++) send(8'h10 + 8'(i), 100, i < 9);
        @(negedge clk);
        chk_reg(2'd2, 32'h80E | PF, "full_and_ovf");
        wr(2'd2, 32'h0000_0008);
        @(negedge clk);
        chk_reg(2'd2, 32'h806 | PF, "ovf_cleared");
        target = t0 + 1 + NB * 100;
        while (cyc < target - 2) @(negedge clk);
        chk_reg(2'd2, 32'h806 | PF, "full_before_pop");
        send(8'hEE, 100, 1'b0);
        @(negedge clk);
        chk_reg(2'd2, 32'h70C | PF, "push_pop_while_full");
        wr(2'd2, 32'h0000_0008);
        drain(12000);

        // Interrupt timing at DIV=2
        wr(2'd1, 32'h0001_0002);
        @(negedge clk);
        chk_bit(IRQ, 1'b0, "irq_ie_latency");
        @(negedge clk);
        chk_bit(IRQ, 1'b1, "irq_before_write");
        send(8'h3C, 2, 1'b1);
        @(negedge clk);
        chk_bit(IRQ, 1'b1, "irq_write_cycle");
        @(negedge clk);
        chk_bit(IRQ, 1'b0, "irq_after_push");
        repeat (NB * 2) @(negedge clk);
        chk_bit(IRQ, 1'b0, "irq_stop_end_edge");
        @(negedge clk);
        chk_bit(IRQ, 1'b1, "irq_drained");
        wr(2'd1, 32'h0000_0002);
        @(negedge clk);
        @(negedge clk);
        chk_bit(IRQ, 1'b0, "irq_ie_off");
        drain(200);

        // Asynchronous reset mid-DATA at DIV=8
        wr(2'd1, 32'h0000_0008);
        mon_en = 1'b0;
        send(8'h5A, 8, 1'b0);
        repeat (13) @(negedge clk);
        chk_bit(txd, 1'b0, "txd_mid_data");
        #2;
        reset = 1'b0;
        #1;
        chk_bit(txd, 1'b1, "txd_async_reset");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        chk_reg(2'd2, 32'h1 | PF, "status_after_abort");
        chk_reg(2'd1, 32'h0000_0010, "ctrl_after_abort");
        repeat (300) @(negedge clk);
        chk_bit(txd, 1'b1, "txd_stays_idle");
        chk_reg(2'd2, 32'h1 | PF, "status_still_idle");

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_left: pending=%0d required=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
